// File: rtl/clocked_video_rx.sv
// Clocked-video receiver: turns a pixel strobe stream with v_sync framing
// into Avalon-ST video packets (header word, pixels, EOP on the last pixel)
// through a show-ahead FIFO, and reports the geometry of the last good frame.
module clocked_video_rx #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] vid_data,
  input  logic              vid_datavalid,
  input  logic              vid_h_sync,
  input  logic              vid_v_sync,
  output logic [DATA_W-1:0] dout_data,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_startofpacket,
  output logic              dout_endofpacket,
  output logic              overflow,
  input  logic              clear_overflow,
  output logic [15:0]       frame_width,
  output logic [15:0]       frame_height
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned WW = DATA_W + 2;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [2:0] {IDLE, WAIT_ACTIVE, ACTIVE, DROP_EOP, DROP} state_t;

  state_t            state_q, state_d;
  logic              vsync_q, dv_q;
  logic              boundary, dv_fall;
  logic [DATA_W-1:0] hold_q;
  logic              load_hold;
  logic              push, push_ok, pop, full;
  logic [WW-1:0]     push_word;
  logic              latch_frame, ovf_set;
  logic [15:0]       pix_q, line_q, lastw_q;
  logic [WW-1:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [AW:0]       cnt_q, cnt_d;
  logic              unused_hsync;

  // h_sync carries no information the receiver needs
  assign unused_hsync = vid_h_sync;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign boundary = vid_v_sync & ~vsync_q;
  assign dv_fall  = dv_q & ~vid_datavalid;

  // Edge-detect registers for v_sync and the pixel strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_q <= 1'b0;
      dv_q    <= 1'b0;
    end else begin
      vsync_q <= vid_v_sync;
      dv_q    <= vid_datavalid;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:        if (boundary) state_d = WAIT_ACTIVE;
      WAIT_ACTIVE: if (vid_datavalid) state_d = full ? DROP : ACTIVE;
      ACTIVE: begin
        if (boundary)                   state_d = full ? DROP_EOP : WAIT_ACTIVE;
        else if (vid_datavalid && full) state_d = DROP_EOP;
      end
      DROP_EOP:    if (!full) state_d = DROP;
      DROP:        if (boundary) state_d = WAIT_ACTIVE;
      default:     state_d = IDLE;
    endcase
  end

  // Output logic: FIFO push request, hold-register load, flag events
  always_comb begin
    push        = 1'b0;
    push_word   = '0;
    load_hold   = 1'b0;
    latch_frame = 1'b0;
    ovf_set     = 1'b0;
    unique case (state_q)
      WAIT_ACTIVE: if (vid_datavalid) begin
        push      = 1'b1;
        push_word = {1'b1, 1'b0, {DATA_W{1'b0}}};
        load_hold = ~full;
        ovf_set   = full;
      end
      ACTIVE: begin
        if (boundary) begin
          push        = 1'b1;
          push_word   = {1'b0, 1'b1, hold_q};
          latch_frame = ~full;
          ovf_set     = full;
        end else if (vid_datavalid) begin
          push      = 1'b1;
          push_word = {1'b0, 1'b0, hold_q};
          load_hold = ~full;
          ovf_set   = full;
        end
      end
      DROP_EOP: begin
        push      = ~full;
        push_word = {1'b0, 1'b1, {DATA_W{1'b0}}};
      end
      default: ;
    endcase
  end

  // One-entry pixel hold so the final pixel can be tagged with EOP
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          hold_q <= '0;
    else if (load_hold) hold_q <= vid_data;
  end

  // Sticky overflow; a new event beats a simultaneous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               overflow <= 1'b0;
    else if (ovf_set)        overflow <= 1'b1;
    else if (clear_overflow) overflow <= 1'b0;
  end

  // Pixel/line counters; lastw_q keeps the finished line's width because the
  // pixel count is already zero by the time the frame-ending v_sync arrives
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_q   <= '0;
      line_q  <= '0;
      lastw_q <= '0;
    end else if (boundary) begin
      pix_q   <= '0;
      line_q  <= '0;
      lastw_q <= '0;
    end else if (vid_datavalid) begin
      pix_q <= sat_inc(pix_q);
    end else if (dv_fall) begin
      line_q  <= sat_inc(line_q);
      lastw_q <= pix_q;
      pix_q   <= '0;
    end
  end

  // Frame geometry, captured only when a complete frame is closed with EOP
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_width  <= '0;
      frame_height <= '0;
    end else if (latch_frame) begin
      frame_width  <= dv_fall ? pix_q : lastw_q;
      frame_height <= dv_fall ? sat_inc(line_q) : line_q;
    end
  end

  assign full    = (cnt_q == FULL_CNT);
  assign push_ok = push & ~full;
  assign pop     = dout_valid & dout_ready;

  // FIFO occupancy next value
  always_comb begin
    cnt_d = cnt_q;
    if (push_ok && !pop)      cnt_d = cnt_q + CNT_ONE;
    else if (!push_ok && pop) cnt_d = cnt_q - CNT_ONE;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + PTR_ONE;
      if (pop)     rd_q <= rd_q + PTR_ONE;
      cnt_q <= cnt_d;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= push_word;
  end

  assign dout_valid         = (cnt_q != '0);
  assign dout_data          = mem_q[rd_q][DATA_W-1:0];
  assign dout_startofpacket = dout_valid & mem_q[rd_q][DATA_W+1];
  assign dout_endofpacket   = dout_valid & mem_q[rd_q][DATA_W];

endmodule

// File: doc/clocked_video_rx.md
CLOCKED_VIDEO_RX -- requirements
Module: clocked_video_rx

Interface
REQ-001 The block SHALL provide parameter DATA_W, default 32, pixel word width in bits.
REQ-002 The block SHALL provide parameter FIFO_DEPTH, default 16, output FIFO entries; power of two, minimum 4.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset, with no other clock domain.
REQ-004 clk  in  1  sole clock; the video timing inputs are synchronous to it.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 vid_data  in  DATA_W  pixel word, qualified by vid_datavalid.
REQ-007 vid_datavalid  in  1  active-picture pixel strobe.
REQ-008 vid_h_sync  in  1  line sync, active-high; informational only.
REQ-009 vid_v_sync  in  1  frame sync, active-high.
REQ-010 dout_data  out  DATA_W  Avalon-ST video data.
REQ-011 dout_valid  out  1  Avalon-ST valid.
REQ-012 dout_ready  in  1  Avalon-ST ready; ready latency 0.
REQ-013 dout_startofpacket  out  1  marks the packet header word.
REQ-014 dout_endofpacket  out  1  marks the last word of a packet.
REQ-015 overflow  out  1  sticky flag: a frame was dropped.
REQ-016 clear_overflow  in  1  one-cycle pulse that clears overflow.
REQ-017 frame_width  out  16  pixels in the last line of the last complete frame.
REQ-018 frame_height  out  16  lines in the last complete frame.

Function
REQ-019 The frame boundary SHALL be the v_sync rising edge, i.e. vid_v_sync=1 with its registered previous value at 0.
REQ-020 The state machine SHALL have states IDLE, WAIT_ACTIVE, ACTIVE, DROP_EOP and DROP.
  - IDLE -> WAIT_ACTIVE on a boundary.
  - WAIT_ACTIVE -> ACTIVE on the first vid_datavalid.
  - ACTIVE -> WAIT_ACTIVE on a boundary.
  - ACTIVE -> DROP_EOP on a required push while the FIFO is full.
  - DROP_EOP -> DROP once the FIFO is not full.
  - WAIT_ACTIVE -> DROP on a required push while the FIFO is full.
  - DROP -> WAIT_ACTIVE on a boundary.
REQ-021 On the first pixel in WAIT_ACTIVE, the block SHALL push header word {sop=1, eop=0, data=0}, packet type 0, and load the pixel into a one-entry hold register.
REQ-022 On each further pixel in ACTIVE, the block SHALL push the hold register {sop=0, eop=0} and load the new pixel.
REQ-023 On a boundary in ACTIVE, the block SHALL push the hold register with eop=1, so the last pixel of a frame carries EOP.
REQ-024 The block SHALL perform at most one FIFO push per cycle; inputs guarantee vid_datavalid=0 in the v_sync-edge cycle.
REQ-025 In DROP_EOP, the block SHALL push {sop=0, eop=1, data=0} when the FIFO is not full, closing the truncated packet.
REQ-026 In DROP, the block SHALL discard all pixels.
REQ-027 On entry to DROP_EOP or DROP, the block SHALL set overflow.
REQ-028 If clear_overflow coincides with a new overflow event, set SHALL win.
REQ-029 The FIFO SHALL be show-ahead: a word pushed in cycle N is visible on dout with dout_valid=1 in cycle N+1.
REQ-030 A word SHALL pop when dout_valid and dout_ready are both 1; push and pop in the same cycle when full SHALL be refused.
REQ-031 dout_data, dout_startofpacket and dout_endofpacket SHALL hold stable while dout_valid=1 and dout_ready=0.
REQ-032 Pixel count SHALL increment per pixel and reset on a vid_datavalid falling edge.
REQ-033 The line counter SHALL increment on each vid_datavalid falling edge.
REQ-034 Counters SHALL saturate at 16'hFFFF.
REQ-035 On the EOP push in REQ-023 only, the block SHALL latch frame_width and frame_height and clear the counters; dropped frames SHALL leave them unchanged.

Reset
REQ-036 Reset SHALL force state IDLE, FIFO empty, hold register empty, counters 0.
REQ-037 Reset SHALL force dout_valid=0, dout_startofpacket=0, dout_endofpacket=0, overflow=0, frame_width=0, frame_height=0.
REQ-038 Reset mid-frame SHALL discard partial data; capture SHALL resume at the next v_sync rising edge and SHALL NOT emit an EOP for the interrupted frame.

Verification
REQ-039 Stimulus: v_sync edge, 2 lines of 4 pixels A0..A3, B0..B3, v_sync edge, dout_ready=1. Response: 9 words, header(sop) then A0..B3, eop on B3; frame_width=4, frame_height=2.
REQ-040 Stimulus: same frame with dout_ready toggled 1/0 every cycle. Response: identical word sequence and flags, with no output change while stalled.
REQ-041 Stimulus: FIFO_DEPTH=4, dout_ready=0, 8-pixel line, then ready=1. Response: overflow=1, header plus 3 pixels, then data=0 with eop; frame_width and frame_height unchanged.
REQ-042 Stimulus: clear_overflow pulse in the same cycle as a new overflow. Response: overflow stays 1; a later lone pulse clears it to 0.
REQ-043 Stimulus: reset asserted after 2 pixels, released, then a full 4x2 frame. Response: outputs reach reset values immediately; only the new frame is output, with a single sop and a single eop.
REQ-044 Stimulus: pixels before the first v_sync edge. Response: ignored, and dout_valid stays 0.
